// File: rtl/pp_stage_pkg.sv
// Shared types and defaults for the pp skid stage.
package pp_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int DEFAULT_WIDTH       = 128;
    localparam int DEFAULT_STALL_CNT_W = 16;

endpackage

// File: rtl/pp_skid_reg.sv
// WIDTH-bit data register with load enable and asynchronous active-low clear.
module pp_skid_reg #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pp_skid_stage.sv
// Two-entry valid/ready skid stage (head + skid register) feeding the pass-through "in" bus.
// Define PP_SKID_STATS_EN to build the saturating stall counter; otherwise stall_cnt is 0.
module pp_skid_stage
    import pp_stage_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int STALL_CNT_W = DEFAULT_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    skid_state_e      state_d;
    skid_state_e      state_q;
    logic             push;
    logic             pop;
    logic             head_load;
    logic             skid_load;
    logic [WIDTH-1:0] head_in;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;

    // in_ready decodes registered state only, so there is no out_ready -> in_ready path.
    assign in_ready  = (state_q != FULL) & rst_n;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head refills from the skid entry when draining FULL, else from the input.
    assign head_in = (state_q == FULL) ? skid_q : in_data;

    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        skid_load = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_load = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pp_skid_reg #(.WIDTH(WIDTH)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .d     (head_in),
        .q     (head_q)
    );

    pp_skid_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PP_SKID_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturates at all-ones; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
